// File: rtl/phase_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// simple_pkg
// Shared definitions for the SIMPLE phase sequencer slice.
//   state_e    : sequencer state encoding (IDLE, RUN, HALTED)
//   NPH_DEF    : default number of phases per instruction (legal 2..8)
//   CNT_W_DEF  : default width of the retired-instruction counter
// ---------------------------------------------------------------------------
package simple_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam int NPH_DEF   = 5;
    localparam int CNT_W_DEF = 16;

endpackage : simple_pkg

// File: rtl/phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// phase_sequencer_if
// Bundles the sequencer's control inputs and its phase/status outputs.
//   exec_pulse : one-cycle start/pause pulse (synchronous to clk)
//   halt_req   : halt request from the control unit, looked at in the last phase
//   p          : one-hot phase enables, p[0] first phase, p[NPH-1] last
//   running    : sequencer is executing instructions
//   halted     : sequencer stopped on a halt; only reset leaves it
//   inst_count : retired-instruction counter (wraps)
// Modports:
//   master : the sequencer (drives p/status, reads exec_pulse/halt_req)
//   slave  : the environment (drives exec_pulse/halt_req, reads p/status)
// ---------------------------------------------------------------------------
interface phase_sequencer_if
    import simple_pkg::*;
#(
    parameter int NPH   = NPH_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic             exec_pulse;
    logic             halt_req;
    logic [NPH-1:0]   p;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] inst_count;

    modport master (
        input  exec_pulse,
        input  halt_req,
        output p,
        output running,
        output halted,
        output inst_count
    );

    modport slave (
        output exec_pulse,
        output halt_req,
        input  p,
        input  running,
        input  halted,
        input  inst_count
    );

endinterface : phase_sequencer_if

// File: rtl/phase_sequencer_phase_ring.sv
// ---------------------------------------------------------------------------
// phase_ring
// One-hot phase rotator.
//   clk : system clock
//   rst : synchronous active-high reset, clears the ring
//   clr : forces the ring to all zeros (takes priority over adv)
//   adv : advance; loads phase 0 from the empty ring, otherwise rotates
//         p[k] -> p[k+1] with p[NPH-1] wrapping back to p[0]
//   p   : registered one-hot phase vector
// With neither clr nor adv the ring holds its value.
// ---------------------------------------------------------------------------
module phase_ring
    import simple_pkg::*;
#(
    parameter int NPH = NPH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           adv,
    output logic [NPH-1:0] p
);

    localparam logic [NPH-1:0] PH0 = {{(NPH-1){1'b0}}, 1'b1};

    logic [NPH-1:0] p_r;
    logic [NPH-1:0] p_nxt_s;

    // Next ring value: clear, load first phase, rotate or hold.
    always_comb begin
        p_nxt_s = p_r;
        if (clr) begin
            p_nxt_s = {NPH{1'b0}};
        end else if (adv) begin
            if (p_r == {NPH{1'b0}}) begin
                p_nxt_s = PH0;
            end else begin
                p_nxt_s = {p_r[NPH-2:0], p_r[NPH-1]};
            end
        end else begin
            p_nxt_s = p_r;
        end
    end

    // Ring register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_r <= {NPH{1'b0}};
        end else begin
            p_r <= p_nxt_s;
        end
    end

    assign p = p_r;

endmodule : phase_ring

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
// Generates the one-hot instruction-phase enables for the SIMPLE datapath,
// starts/pauses execution from exec_pulse, stops on halt_req in the last
// phase and counts retired instructions.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset (overrides everything)
//   step_mode : (only with PHASE_SEQUENCER_STEP_EN) when high, a start from
//               IDLE runs exactly one instruction and returns to IDLE
//   bus       : phase_sequencer_if.master (exec_pulse, halt_req in;
//               p, running, halted, inst_count out)
// Optional feature macro: PHASE_SEQUENCER_STEP_EN (single-step mode).
// All outputs are registered; none depends combinationally on an input.
// ---------------------------------------------------------------------------
module phase_sequencer
    import simple_pkg::*;
#(
    parameter int NPH   = NPH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
`ifdef PHASE_SEQUENCER_STEP_EN
    input  logic                step_mode,
`endif
    phase_sequencer_if.master   bus
);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             pause_r;
    logic             pause_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             running_r;
    logic             halted_r;
    logic             clr_s;
    logic             adv_s;
    logic             last_s;
    logic             step_entry_s;
    logic [NPH-1:0]   p_s;

    // A single-step start is simply a start with the pause already pending,
    // so the instruction completes and any exec_pulse during it is absorbed.
`ifdef PHASE_SEQUENCER_STEP_EN
    assign step_entry_s = step_mode;
`else
    assign step_entry_s = 1'b0;
`endif

    assign last_s = p_s[NPH-1];

    phase_ring #(
        .NPH (NPH)
    ) u_ring (
        .clk (clk),
        .rst (rst),
        .clr (clr_s),
        .adv (adv_s),
        .p   (p_s)
    );

    // Next-state, pause flag, counter and ring control.
    always_comb begin
        state_nxt_s = state_r;
        pause_nxt_s = pause_r;
        count_nxt_s = count_r;
        clr_s       = 1'b0;
        adv_s       = 1'b0;
        case (state_r)
            IDLE: begin
                pause_nxt_s = 1'b0;
                if (bus.exec_pulse) begin
                    state_nxt_s = RUN;
                    adv_s       = 1'b1;
                    pause_nxt_s = step_entry_s;
                end else begin
                    state_nxt_s = IDLE;
                    clr_s       = 1'b1;
                end
            end
            RUN: begin
                if (last_s) begin
                    // Halted and paused instructions still retire.
                    count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    pause_nxt_s = 1'b0;
                    if (bus.halt_req) begin
                        state_nxt_s = HALTED;
                        clr_s       = 1'b1;
                    end else if (pause_r || bus.exec_pulse) begin
                        state_nxt_s = IDLE;
                        clr_s       = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                        adv_s       = 1'b1;
                    end
                end else begin
                    state_nxt_s = RUN;
                    adv_s       = 1'b1;
                    pause_nxt_s = pause_r | bus.exec_pulse;
                end
            end
            HALTED: begin
                state_nxt_s = HALTED;
                pause_nxt_s = 1'b0;
                clr_s       = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
                pause_nxt_s = 1'b0;
                clr_s       = 1'b1;
            end
        endcase
    end

    // State, pause flag, counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pause_r   <= 1'b0;
            count_r   <= {CNT_W{1'b0}};
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pause_r   <= pause_nxt_s;
            count_r   <= count_nxt_s;
            running_r <= (state_nxt_s == RUN);
            halted_r  <= (state_nxt_s == HALTED);
        end
    end

    assign bus.p          = p_s;
    assign bus.running    = running_r;
    assign bus.halted     = halted_r;
    assign bus.inst_count = count_r;

endmodule : phase_sequencer

// File: tb/tb_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_phase_sequencer
// Self-checking bench for phase_sequencer: a vector table of the directed
// scenarios, hand-written multi-cycle sequences and randomized stimulus
// checked against a behavioural model. A second instance with a 3-bit
// counter exercises counter wrap-around within a short run.
// ---------------------------------------------------------------------------
module tb_phase_sequencer;

    localparam int NPH = 5;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic exec_i = 1'b0;
    logic halt_i = 1'b0;
    logic step_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phase_sequencer_if #(.NPH(NPH), .CNT_W(16)) bus_s ();
    phase_sequencer_if #(.NPH(NPH), .CNT_W(3))  bus_small_s ();

    assign bus_s.exec_pulse       = exec_i;
    assign bus_s.halt_req         = halt_i;
    assign bus_small_s.exec_pulse = exec_i;
    assign bus_small_s.halt_req   = halt_i;

    phase_sequencer #(.NPH(NPH), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst_i),
`ifdef PHASE_SEQUENCER_STEP_EN
        .step_mode (step_i),
`endif
        .bus       (bus_s.master)
    );

    phase_sequencer #(.NPH(NPH), .CNT_W(3)) dut_small (
        .clk       (clk),
        .rst       (rst_i),
`ifdef PHASE_SEQUENCER_STEP_EN
        .step_mode (step_i),
`endif
        .bus       (bus_small_s.master)
    );

    // Behavioural model: phase number (-1 = no phase), activity flags,
    // pending-pause flag and a count of retired instructions.
    int          m_ph = -1;
    bit          m_run = 1'b0;
    bit          m_halted = 1'b0;
    bit          m_pend = 1'b0;
    logic [15:0] m_cnt = 16'd0;

    task automatic model_update();
        if (rst_i) begin
            m_ph = -1; m_run = 1'b0; m_halted = 1'b0; m_pend = 1'b0; m_cnt = 16'd0;
        end else if (m_halted) begin
            m_ph = -1;
        end else if (!m_run) begin
            if (exec_i) begin
                m_run  = 1'b1;
                m_ph   = 0;
                m_pend = step_i;
            end
        end else if (m_ph == NPH - 1) begin
            m_cnt = m_cnt + 16'd1;
            if (halt_i) begin
                m_run = 1'b0; m_halted = 1'b1; m_ph = -1; m_pend = 1'b0;
            end else if (m_pend || exec_i) begin
                m_run = 1'b0; m_ph = -1; m_pend = 1'b0;
            end else begin
                m_ph = 0;
            end
        end else begin
            m_ph = m_ph + 1;
            if (exec_i) m_pend = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Inputs are stable across the edge; the model advances with the DUT,
    // and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [31:0] exp_p;
        exp_p = (m_ph < 0) ? 32'd0 : (32'd1 << m_ph);
        check({tag, ".p"},       {27'd0, bus_s.p},          exp_p);
        check({tag, ".running"}, {31'd0, bus_s.running},    {31'd0, m_run});
        check({tag, ".halted"},  {31'd0, bus_s.halted},     {31'd0, m_halted});
        check({tag, ".count"},   {16'd0, bus_s.inst_count}, {16'd0, m_cnt});
        check({tag, ".count3"},  {29'd0, bus_small_s.inst_count}, {29'd0, m_cnt[2:0]});
        check({tag, ".p_small"}, {27'd0, bus_small_s.p},    exp_p);
    endtask

    typedef struct {
        logic        rst;
        logic        exec;
        logic        halt;
        logic [4:0]  p;
        logic        run;
        logic        hlt;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic h,
                                input logic [4:0] p, input logic run,
                                input logic hlt, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.exec = e; v.halt = h; v.p = p; v.run = run; v.hlt = hlt; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        // Directed vector table: inputs before the edge, outputs after it.
        tbl.push_back(mk(1, 0, 0, 5'b00000, 0, 0, 16'd0)); // reset
        tbl.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 16'd0)); // idle holds
        tbl.push_back(mk(0, 1, 0, 5'b00001, 1, 0, 16'd0)); // start, 1-cycle latency
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00100, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b01000, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b10000, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00001, 1, 0, 16'd1)); // wrap, first retire
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd1));
        tbl.push_back(mk(0, 0, 0, 5'b00100, 1, 0, 16'd1));
        tbl.push_back(mk(0, 0, 1, 5'b01000, 1, 0, 16'd1)); // halt in p[2] ignored
        tbl.push_back(mk(0, 0, 0, 5'b10000, 1, 0, 16'd1));
        tbl.push_back(mk(0, 0, 0, 5'b00001, 1, 0, 16'd2));
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd2));
        tbl.push_back(mk(0, 1, 0, 5'b00100, 1, 0, 16'd2)); // pause in p[1]
        tbl.push_back(mk(0, 0, 0, 5'b01000, 1, 0, 16'd2));
        tbl.push_back(mk(0, 0, 0, 5'b10000, 1, 0, 16'd2));
        tbl.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 16'd3)); // paused after retire
        tbl.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 16'd3));
        tbl.push_back(mk(0, 1, 0, 5'b00001, 1, 0, 16'd3)); // resume at p[0]
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd3));
        tbl.push_back(mk(0, 0, 0, 5'b00100, 1, 0, 16'd3));
        tbl.push_back(mk(0, 0, 0, 5'b01000, 1, 0, 16'd3));
        tbl.push_back(mk(0, 0, 0, 5'b10000, 1, 0, 16'd3));
        tbl.push_back(mk(0, 1, 1, 5'b00000, 0, 1, 16'd4)); // halt beats pause
        tbl.push_back(mk(0, 1, 0, 5'b00000, 0, 1, 16'd4)); // exec ignored when halted
        tbl.push_back(mk(0, 0, 1, 5'b00000, 0, 1, 16'd4));
        tbl.push_back(mk(1, 1, 0, 5'b00000, 0, 0, 16'd0)); // reset wins
        tbl.push_back(mk(0, 1, 0, 5'b00001, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00100, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b01000, 1, 0, 16'd0));
        tbl.push_back(mk(1, 0, 0, 5'b00000, 0, 0, 16'd0)); // reset in p[3]
        tbl.push_back(mk(0, 0, 0, 5'b00000, 0, 0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 5'b00001, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00010, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b00100, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b01000, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 0, 5'b10000, 1, 0, 16'd0));
        tbl.push_back(mk(0, 0, 1, 5'b00000, 0, 1, 16'd1)); // halt in last phase
        tbl.push_back(mk(0, 1, 0, 5'b00000, 0, 1, 16'd1));
        tbl.push_back(mk(1, 0, 0, 5'b00000, 0, 0, 16'd0)); // reset leaves HALTED

        #1;
        foreach (tbl[i]) begin
            rst_i  = tbl[i].rst;
            exec_i = tbl[i].exec;
            halt_i = tbl[i].halt;
            tick();
            check($sformatf("vec%0d.p", i),       {27'd0, bus_s.p},          {27'd0, tbl[i].p});
            check($sformatf("vec%0d.running", i), {31'd0, bus_s.running},    {31'd0, tbl[i].run});
            check($sformatf("vec%0d.halted", i),  {31'd0, bus_s.halted},     {31'd0, tbl[i].hlt});
            check($sformatf("vec%0d.count", i),   {16'd0, bus_s.inst_count}, {16'd0, tbl[i].cnt});
        end

        // Eight back-to-back instructions: the 3-bit counter wraps to 0.
        rst_i = 1'b1; exec_i = 1'b0; halt_i = 1'b0;
        tick();
        rst_i = 1'b0; exec_i = 1'b1;
        tick();
        exec_i = 1'b0;
        for (int c = 0; c < 8 * NPH; c++) begin
            tick();
            check_model("seq_run");
        end
        check("wrap.count3", {29'd0, bus_small_s.inst_count}, 32'd0);
        check("wrap.count16", {16'd0, bus_s.inst_count}, 32'd8);

        // Pause pulse in the last phase itself takes effect at that edge.
        while (m_ph != NPH - 1) tick();
        exec_i = 1'b1;
        tick();
        exec_i = 1'b0;
        check("lastpause.running", {31'd0, bus_s.running}, 32'd0);
        check("lastpause.p", {27'd0, bus_s.p}, 32'd0);
        check_model("lastpause");

`ifdef PHASE_SEQUENCER_STEP_EN
        // Single step: each start gives NPH phases then IDLE, one retire.
        step_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            logic [15:0] base;
            base = bus_s.inst_count;
            exec_i = 1'b1;
            tick();
            exec_i = 1'b0;
            for (int c = 0; c < NPH - 1; c++) begin
                exec_i = (c == 1) ? 1'b1 : 1'b0;
                check("step.running", {31'd0, bus_s.running}, 32'd1);
                tick();
            end
            exec_i = 1'b0;
            check("step.last", {27'd0, bus_s.p}, 32'd1 << (NPH - 1));
            tick();
            check("step.idle", {31'd0, bus_s.running}, 32'd0);
            check("step.count", {16'd0, bus_s.inst_count}, {16'd0, base + 16'd1});
            check_model("step");
        end
        step_i = 1'b0;
`endif

        // Randomized stimulus against the behavioural model.
        rst_i = 1'b1;
        tick();
        for (int c = 0; c < 4000; c++) begin
            bit busy;
            busy   = (c < 2000);
            rst_i  = busy ? ($urandom_range(0, 499) == 0) : ($urandom_range(0, 79) == 0);
            exec_i = ($urandom_range(0, 7) == 0);
            halt_i = busy ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 4) == 0);
`ifdef PHASE_SEQUENCER_STEP_EN
            step_i = ($urandom_range(0, 2) == 0);
`endif
            tick();
            check_model("rand");
            if (bus_s.running && bus_s.halted) begin
                check("rand.exclusive", 32'd1, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_phase_sequencer
